// File: rtl/ghost_scheduler_pkg.sv
// ghost_scheduler_pkg
//   Shared types and helpers for the ghost scheduler.
//   mode_t  : global ghost mode encoding (scatter / chase / frightened).
//   cnt_width : bit width needed to hold values 0..max_val.
package ghost_scheduler_pkg;

    typedef enum logic [1:0] {
        MODE_SCATTER = 2'd0,
        MODE_CHASE   = 2'd1,
        MODE_FRIGHT  = 2'd2
    } mode_t;

    localparam int NUM_GHOSTS = 4;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ghost_scheduler_tick_divider.sv
// tick_divider
//   Divides the system clock into movement ticks.
//   Ports:
//     clk    in  system clock
//     reset  in  asynchronous active-high reset
//     enable in  count only while high; the count holds while low
//     tick   out high during the cycle whose closing edge wraps the count
//                (i.e. the next rising edge is a tick edge)
module tick_divider
    import ghost_scheduler_pkg::*;
#(
    parameter int DIV = 2500000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int W = cnt_width(DIV - 1);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] div_cnt;

    assign tick = enable && (div_cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (enable) begin
            div_cnt <= tick ? '0 : div_cnt + W'(1);
        end
    end

endmodule

// File: rtl/ghost_scheduler.sv
// ghost_scheduler
//   Central sequencer for the four ghost movement controllers: movement tick
//   generation, per-ghost step strobes, staggered house release and the
//   global scatter / chase / frightened mode machine.
//   Ports:
//     clk           in  system clock
//     reset         in  asynchronous active-high reset
//     enable        in  game running; low freezes all counters and ticks
//     pellet_eaten  in  one-cycle pulse, power pellet consumed
//     ghost_caught  in  one-cycle pulse per ghost, ghost eaten by player
//     mode          out current global mode (mode_t encoding)
//     step_en       out one-cycle strobe per ghost, advance one step
//     released      out ghost has left the house (sticky)
//     frightened    out ghost is vulnerable
//     reverse       out one-cycle pulse, ghost must reverse direction
module ghost_scheduler
    import ghost_scheduler_pkg::*;
#(
    parameter int TICK_DIV      = 2500000,
    parameter int SCATTER_STEPS = 140,
    parameter int CHASE_STEPS   = 400,
    parameter int FRIGHT_STEPS  = 120,
    parameter int RELEASE_GAP   = 60,
    parameter int SCATTER_WAVES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       pellet_eaten,
    input  logic [3:0] ghost_caught,
    output logic [1:0] mode,
    output logic [3:0] step_en,
    output logic [3:0] released,
    output logic [3:0] frightened,
    output logic [3:0] reverse
);

    localparam int PHASE_MAX = (SCATTER_STEPS > CHASE_STEPS) ? SCATTER_STEPS : CHASE_STEPS;
    localparam int PHASE_W   = cnt_width(PHASE_MAX);
    localparam int FRIGHT_W  = cnt_width(FRIGHT_STEPS);
    localparam int WAVE_W    = cnt_width(SCATTER_WAVES);
    localparam int ELAP_W    = cnt_width(3 * RELEASE_GAP);

    localparam logic [PHASE_W-1:0]  PH_SCATTER = PHASE_W'(SCATTER_STEPS);
    localparam logic [PHASE_W-1:0]  PH_CHASE   = PHASE_W'(CHASE_STEPS);
    localparam logic [PHASE_W-1:0]  PH_ONE     = PHASE_W'(1);
    localparam logic [FRIGHT_W-1:0] FR_LOAD    = FRIGHT_W'(FRIGHT_STEPS);
    localparam logic [FRIGHT_W-1:0] FR_ONE     = FRIGHT_W'(1);
    localparam logic [WAVE_W-1:0]   WAVE_MAX   = WAVE_W'(SCATTER_WAVES);
    localparam logic [ELAP_W-1:0]   ELAP_MAX   = ELAP_W'(3 * RELEASE_GAP);

    logic tick;

    mode_t               state, state_next;
    mode_t               saved_mode, saved_next;
    logic [PHASE_W-1:0]  phase_cnt, phase_next;
    logic [WAVE_W-1:0]   wave, wave_next;
    logic [FRIGHT_W-1:0] fright_cnt, fright_next;
    logic [ELAP_W-1:0]   elapsed, elapsed_next;
    logic                half, half_next;
    logic [3:0]          released_next, frightened_next, step_next, reverse_next;

    tick_divider #(
        .DIV(TICK_DIV)
    ) u_tick_divider (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .tick  (tick)
    );

    assign mode = state;

    always_comb begin
        state_next      = state;
        saved_next      = saved_mode;
        phase_next      = phase_cnt;
        wave_next       = wave;
        fright_next     = fright_cnt;
        elapsed_next    = elapsed;
        half_next       = half;
        released_next   = released;
        frightened_next = frightened;
        step_next       = '0;
        reverse_next    = '0;

        if (enable) begin
            // Step strobe uses the state as it was before this tick edge.
            if (tick) begin
                step_next = released & (~frightened | {4{half}});
            end

            // A pellet takes priority over catches and phase ticks on the same edge.
            if (pellet_eaten) begin
                if (state != MODE_FRIGHT) begin
                    saved_next   = state;
                    reverse_next = released;
                end
                state_next      = MODE_FRIGHT;
                fright_next     = FR_LOAD;
                frightened_next = released;
                half_next       = 1'b0;
            end else if (state == MODE_FRIGHT) begin
                frightened_next = frightened & ~ghost_caught;
                if (tick) begin
                    half_next = ~half;
                    if (fright_cnt == FR_ONE) begin
                        state_next      = saved_mode;
                        frightened_next = '0;
                    end else begin
                        fright_next = fright_cnt - FR_ONE;
                    end
                end
            end else if (tick) begin
                case (state)
                    MODE_SCATTER: begin
                        if (phase_cnt == PH_ONE) begin
                            state_next   = MODE_CHASE;
                            phase_next   = PH_CHASE;
                            wave_next    = wave + WAVE_W'(1);
                            reverse_next = released;
                        end else begin
                            phase_next = phase_cnt - PH_ONE;
                        end
                    end
                    MODE_CHASE: begin
                        // Once all scatter waves are spent, chase is permanent.
                        if (wave < WAVE_MAX) begin
                            if (phase_cnt == PH_ONE) begin
                                state_next   = MODE_SCATTER;
                                phase_next   = PH_SCATTER;
                                reverse_next = released;
                            end else begin
                                phase_next = phase_cnt - PH_ONE;
                            end
                        end
                    end
                    default: ;
                endcase
            end

            // Release schedule runs on game time regardless of mode.
            if (tick) begin
                if (elapsed != ELAP_MAX) begin
                    elapsed_next = elapsed + ELAP_W'(1);
                end
                for (int i = 0; i < 4; i++) begin
                    if (elapsed_next >= ELAP_W'(i * RELEASE_GAP)) begin
                        released_next[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= MODE_SCATTER;
            saved_mode <= MODE_SCATTER;
            phase_cnt  <= PH_SCATTER;
            wave       <= '0;
            fright_cnt <= '0;
            elapsed    <= '0;
            half       <= 1'b0;
            released   <= 4'b0001;
            frightened <= '0;
            step_en    <= '0;
            reverse    <= '0;
        end else begin
            state      <= state_next;
            saved_mode <= saved_next;
            phase_cnt  <= phase_next;
            wave       <= wave_next;
            fright_cnt <= fright_next;
            elapsed    <= elapsed_next;
            half       <= half_next;
            released   <= released_next;
            frightened <= frightened_next;
            step_en    <= step_next;
            reverse    <= reverse_next;
        end
    end

endmodule

// File: tb/tb_ghost_scheduler.sv
// tb_ghost_scheduler
//   Scoreboard bench for ghost_scheduler: the stimulus process drives inputs
//   on the falling edge, advances a behavioural model and queues the outputs
//   expected after the next rising edge; a monitor pops and compares them.
module tb_ghost_scheduler;

    localparam int TD = 4;
    localparam int SS = 3;
    localparam int CS = 5;
    localparam int FS = 4;
    localparam int RG = 2;
    localparam int SW = 2;

    localparam int M_SCATTER = 0;
    localparam int M_CHASE   = 1;
    localparam int M_FRIGHT  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       pellet_eaten = 1'b0;
    logic [3:0] ghost_caught = 4'b0;
    logic [1:0] mode;
    logic [3:0] step_en, released, frightened, reverse;

    always #5 clk = ~clk;

    ghost_scheduler #(
        .TICK_DIV(TD), .SCATTER_STEPS(SS), .CHASE_STEPS(CS),
        .FRIGHT_STEPS(FS), .RELEASE_GAP(RG), .SCATTER_WAVES(SW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .pellet_eaten(pellet_eaten), .ghost_caught(ghost_caught),
        .mode(mode), .step_en(step_en), .released(released),
        .frightened(frightened), .reverse(reverse)
    );

    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] step;
        logic [3:0] rel;
        logic [3:0] fr;
        logic [3:0] rev;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural reference: game time measured in whole clock cycles.
    int         m_div, m_elapsed, m_phase, m_wave, m_fcnt, m_mode, m_saved;
    bit         m_half;
    logic [3:0] m_rel, m_fr, m_step, m_rev;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_div = 0; m_elapsed = 0; m_phase = SS; m_wave = 0; m_fcnt = 0;
        m_mode = M_SCATTER; m_saved = M_SCATTER; m_half = 0;
        m_rel = 4'b0001; m_fr = 4'b0; m_step = 4'b0; m_rev = 4'b0;
    endtask

    task automatic model_step(input bit rst, input bit en, input bit pel, input logic [3:0] caught);
        bit         is_tick;
        logic [3:0] rel_before;
        if (rst) begin
            model_reset();
            return;
        end
        m_step = 4'b0;
        m_rev  = 4'b0;
        if (!en) return;
        is_tick    = (m_div == TD - 1);
        m_div      = is_tick ? 0 : m_div + 1;
        rel_before = m_rel;
        if (is_tick) begin
            for (int i = 0; i < 4; i++)
                m_step[i] = rel_before[i] && (!m_fr[i] || m_half);
        end
        if (pel) begin
            if (m_mode != M_FRIGHT) begin
                m_saved = m_mode;
                m_rev   = rel_before;
            end
            m_mode = M_FRIGHT; m_fcnt = FS; m_fr = rel_before; m_half = 0;
        end else if (m_mode == M_FRIGHT) begin
            m_fr = m_fr & ~caught;
            if (is_tick) begin
                m_half = !m_half;
                if (m_fcnt == 1) begin
                    m_mode = m_saved;
                    m_fr   = 4'b0;
                end else begin
                    m_fcnt--;
                end
            end
        end else if (is_tick) begin
            if (m_mode == M_SCATTER) begin
                if (m_phase == 1) begin
                    m_mode = M_CHASE; m_phase = CS; m_wave++; m_rev = rel_before;
                end else m_phase--;
            end else if (m_wave < SW) begin
                if (m_phase == 1) begin
                    m_mode = M_SCATTER; m_phase = SS; m_rev = rel_before;
                end else m_phase--;
            end
        end
        if (is_tick) begin
            if (m_elapsed < 3 * RG) m_elapsed++;
            for (int i = 0; i < 4; i++)
                if (m_elapsed >= i * RG) m_rel[i] = 1'b1;
        end
    endtask

    // One clock of stimulus: drive on the falling edge, queue the expectation.
    task automatic cyc(input bit rst, input bit en, input bit pel, input logic [3:0] caught);
        bit was_rst;
        @(negedge clk);
        was_rst      = reset;
        reset        = rst;
        enable       = en;
        pellet_eaten = pel;
        ghost_caught = caught;
        model_step(rst, en, pel, caught);
        exp_q.push_back('{mode: 2'(m_mode), step: m_step, rel: m_rel, fr: m_fr, rev: m_rev});
        if (rst && !was_rst) begin
            #1;
            chk("async_reset_mode", int'(mode), M_SCATTER);
            chk("async_reset_released", int'(released), 1);
            chk("async_reset_frightened", int'(frightened), 0);
            chk("async_reset_step_en", int'(step_en), 0);
            chk("async_reset_reverse", int'(reverse), 0);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("mode", int'(mode), int'(e.mode));
                chk("step_en", int'(step_en), int'(e.step));
                chk("released", int'(released), int'(e.rel));
                chk("frightened", int'(frightened), int'(e.fr));
                chk("reverse", int'(reverse), int'(e.rev));
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int g;
        model_reset();
        repeat (3) cyc(1, 0, 0, 4'b0);

        // Free run from reset: first three ticks, then permanent chase.
        repeat (12) cyc(0, 1, 0, 4'b0);
        settle();
        chk("tick3_mode", int'(mode), M_CHASE);
        chk("tick3_step_en", int'(step_en), 4'b0011);
        chk("tick3_reverse", int'(reverse), 4'b0011);
        repeat (168) cyc(0, 1, 0, 4'b0);
        settle();
        chk("tick45_mode", int'(mode), M_CHASE);
        chk("tick45_released", int'(released), 4'b1111);

        // Mid-chase reset, then catches in scatter and fright scenarios.
        repeat (2) cyc(1, 0, 0, 4'b0);
        repeat (5) cyc(0, 1, 0, 4'b0);
        cyc(0, 1, 0, 4'b0100);
        for (g = 0; g < 300 && !(m_mode == M_CHASE && m_phase == 3); g++) cyc(0, 1, 0, 4'b0);
        settle();
        chk("reach_chase_phase3", int'(mode), M_CHASE);
        cyc(0, 1, 1, 4'b0);
        settle();
        chk("fright_entry_mode", int'(mode), M_FRIGHT);
        chk("fright_entry_frightened", int'(frightened), 4'b0111);
        repeat (3) cyc(0, 1, 0, 4'b0);
        cyc(0, 1, 0, 4'b0100);
        settle();
        chk("caught_clears_ghost2", int'(frightened), 4'b0011);
        repeat (5) cyc(0, 1, 0, 4'b0);
        cyc(0, 1, 1, 4'b0);
        for (g = 0; g < 300 && m_mode == M_FRIGHT; g++) cyc(0, 1, 0, 4'b0);
        repeat (20) cyc(0, 1, 0, 4'b0);

        // Pellet on the very tick edge that would end a scatter phase.
        for (g = 0; g < 400 && !(m_mode == M_SCATTER && m_phase == 1 && m_div == TD - 1); g++)
            cyc(0, 1, 0, 4'b0);
        cyc(0, 1, 1, 4'b0);
        settle();
        chk("pellet_on_tick_mode", int'(mode), M_FRIGHT);
        repeat (40) cyc(0, 1, 0, 4'b0);

        // Enable low: events ignored, strobes silent, state frozen.
        repeat (2) cyc(0, 1, 0, 4'b0);
        repeat (10) cyc(0, 0, 1, 4'b1111);
        repeat (8) cyc(0, 1, 0, 4'b0);
        cyc(0, 1, 1, 4'b0);
        repeat (6) cyc(0, 1, 0, 4'b0);
        cyc(1, 1, 0, 4'b0);
        cyc(1, 1, 0, 4'b0);

        // Randomised traffic.
        for (int i = 0; i < 1200; i++) begin
            bit         r_rst, r_en, r_pel;
            logic [3:0] r_caught;
            r_rst    = ($urandom_range(0, 299) == 0);
            r_en     = ($urandom_range(0, 15) != 0);
            r_pel    = ($urandom_range(0, 39) == 0);
            r_caught = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            cyc(r_rst, r_en, r_pel, r_caught);
        end
        cyc(0, 1, 0, 4'b0);

        @(posedge clk);
        #3;
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
